// File: rtl/ntt_pkg.sv
// ============================================================================
// ntt_pkg
// ----------------------------------------------------------------------------
// Shared types and pointer-width helpers for the NTT input stage.
//   bank_state_t : occupancy state of one ping-pong bank
//   ld_fsm_t     : output burst FSM states
//   wptr_width() / rptr_width() : pointer widths for a given POLY_N
// DATA_WIDTH stays a global macro so every NTT block agrees on it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ntt_pkg;

  localparam int DEFAULT_POLY_N = 256;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ld_fsm_t;

  // Write pointer spans a whole polynomial; its MSB picks the lo/hi half.
  function automatic int wptr_width(input int poly_n);
    return $clog2(poly_n);
  endfunction

  // Read pointer spans one half (one butterfly pair per address).
  function automatic int rptr_width(input int poly_n);
    return $clog2(poly_n) - 1;
  endfunction

  localparam int WPTR_W = wptr_width(DEFAULT_POLY_N);
  localparam int RPTR_W = rptr_width(DEFAULT_POLY_N);

endpackage

`default_nettype wire

// File: rtl/coef_bank.sv
// ============================================================================
// coef_bank
// ----------------------------------------------------------------------------
// Simple dual-port coefficient RAM: one write port, one registered read port.
//   clk      in  : clock
//   rst      in  : asynchronous active-low reset (read register only)
//   wr_en    in  : write strobe
//   wr_addr  in  : write address
//   wr_data  in  : write data
//   rd_en    in  : read strobe; rd_data updates one edge later
//   rd_addr  in  : read address
//   rd_data  out : registered read data, holds when rd_en is low
// Storage itself is not reset; only the read register is cleared.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module coef_bank #(
  parameter int DEPTH = 128,
  parameter int WIDTH = `DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_loader.sv
// ============================================================================
// ntt_loader
// ----------------------------------------------------------------------------
// Ping-pong input stage for the pipelined NTT. Coefficients stream in one per
// transfer; each full polynomial is replayed as a gap-free burst of HALF
// butterfly pairs {a[j], a[j+HALF]} while the next polynomial fills the
// other bank.
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-low reset
//   s_valid  in  : coefficient valid
//   s_ready  out : coefficient can be accepted (registered)
//   s_data   in  : coefficient
//   out_en   out : pair valid (drives ntt.in_en)
//   out[2]   out : out[0]=a[j], out[1]=a[j+HALF] (drives ntt.in)
//   idle     out : both banks empty, no burst, output register empty
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ntt_loader
  import ntt_pkg::*;
#(
  parameter int POLY_N = DEFAULT_POLY_N,
  parameter int HALF   = POLY_N / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [`DATA_WIDTH-1:0] s_data,
  output logic                   out_en,
  output logic [`DATA_WIDTH-1:0] out [2],
  output logic                   idle
);

  localparam int WW = wptr_width(POLY_N);
  localparam int RW = rptr_width(POLY_N);
  localparam int DW = `DATA_WIDTH;

  bank_state_t   bank_st [2];
  bank_state_t   bank_n  [2];
  ld_fsm_t       state, state_n;
  logic          wb, wb_n;
  logic          rb, rb_n;
  logic [WW-1:0] wptr, wptr_n;
  logic [RW-1:0] rptr, rptr_n;
  logic          s_ready_n;
  logic          rd_sel, rd_sel_n;

  logic          xfer;
  logic          fill_done;
  logic          rd_en;
  logic          last_rd;

  logic [DW-1:0] lo_q [2];
  logic [DW-1:0] hi_q [2];

  assign xfer      = s_valid & s_ready;
  assign fill_done = xfer && (wptr == WW'(POLY_N - 1));
  assign rd_en     = (state == BURST);
  assign last_rd   = rd_en && (rptr == RW'(HALF - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      state      <= IDLE;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      s_ready    <= 1'b0;
      out_en     <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      bank_st[0] <= bank_n[0];
      bank_st[1] <= bank_n[1];
      state      <= state_n;
      wb         <= wb_n;
      rb         <= rb_n;
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      s_ready    <= s_ready_n;
      out_en     <= rd_en;
      rd_sel     <= rd_sel_n;
    end
  end

  always_comb begin
    bank_n[0] = bank_st[0];
    bank_n[1] = bank_st[1];
    state_n   = state;
    wb_n      = wb;
    rb_n      = rb;
    wptr_n    = wptr;
    rptr_n    = rptr;
    rd_sel_n  = rd_sel;

    // Write side. wptr wraps to 0 on its own after POLY_N-1.
    if (xfer) begin
      wptr_n = wptr + 1'b1;
      if (bank_st[wb] == EMPTY) begin
        bank_n[wb] = FILLING;
      end
      if (fill_done) begin
        bank_n[wb] = FULL;
        wb_n       = ~wb;
      end
    end

    // Read side. It only ever touches banks that are FULL or DRAINING, and
    // s_ready keeps the writer off those, so the two sides never collide.
    unique case (state)
      IDLE: begin
        if (bank_st[rb] == FULL) begin
          state_n     = BURST;
          bank_n[rb]  = DRAINING;
          rptr_n      = '0;
        end
      end
      BURST: begin
        rptr_n   = rptr + 1'b1;
        rd_sel_n = rb;
        if (last_rd) begin
          bank_n[rb] = EMPTY;
          rb_n       = ~rb;
          if (bank_st[~rb] == FULL) begin
            bank_n[~rb] = DRAINING;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // On the filling edge the writer moves to the other bank, so readiness
    // depends on that bank already being EMPTY. Otherwise it follows the
    // current write bank; a bank freed this edge reopens s_ready one edge later.
    if (fill_done) begin
      s_ready_n = (bank_st[~wb] == EMPTY);
    end else begin
      s_ready_n = (bank_st[wb] == EMPTY) || (bank_st[wb] == FILLING);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);

    coef_bank #(
      .DEPTH (HALF),
      .WIDTH (DW)
    ) u_lo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (xfer && (wb == SEL) && !wptr[WW-1]),
      .wr_addr (wptr[WW-2:0]),
      .wr_data (s_data),
      .rd_en   (rd_en && (rb == SEL)),
      .rd_addr (rptr),
      .rd_data (lo_q[b])
    );

    coef_bank #(
      .DEPTH (HALF),
      .WIDTH (DW)
    ) u_hi (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (xfer && (wb == SEL) && wptr[WW-1]),
      .wr_addr (wptr[WW-2:0]),
      .wr_data (s_data),
      .rd_en   (rd_en && (rb == SEL)),
      .rd_addr (rptr),
      .rd_data (hi_q[b])
    );
  end

  // Only the bank being read updates its read register, and rd_sel keeps
  // pointing at it afterwards, so out holds between bursts.
  assign out[0] = rd_sel ? lo_q[1] : lo_q[0];
  assign out[1] = rd_sel ? hi_q[1] : hi_q[0];

  assign idle = (bank_st[0] == EMPTY) && (bank_st[1] == EMPTY) &&
                (state == IDLE) && !out_en;

endmodule

`default_nettype wire
